// File: rtl/random_seq_monitor_pkg.sv
// Shared definitions for the random-sequence counter checker: FSM states,
// the sequence order, and lookup helpers used by the LUT.
package random_seq_pkg;

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  localparam logic [3:0] SEQ [8] = '{4'd0, 4'd4, 4'd7, 4'd8, 4'd10, 4'd13, 4'd9, 4'd15};

  function automatic logic seq_member(input logic [3:0] q);
    logic m;
    m = 1'b0;
    for (int i = 0; i < 8; i++)
      if (SEQ[i] == q) m = 1'b1;
    return m;
  endfunction

  // Non-members map to position 0; callers qualify with seq_member().
  function automatic logic [2:0] seq_index(input logic [3:0] q);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (SEQ[i] == q) idx = 3'(i);
    return idx;
  endfunction

  function automatic logic [3:0] seq_next(input logic [3:0] q);
    logic [2:0] n;
    n = seq_index(q) + 3'd1;
    return SEQ[n];
  endfunction

endpackage

// File: rtl/random_seq_monitor_lut.sv
// Combinational sequence lookup: membership, successor and position of a
// 4-bit counter value.
module random_seq_lut
  import random_seq_pkg::*;
(
  input  logic [3:0] q,
  output logic       member,
  output logic [3:0] nxt,
  output logic [2:0] index
);

  always_comb begin
    member = seq_member(q);
    nxt    = seq_next(q);
    index  = seq_index(q);
  end

endmodule

// File: rtl/random_seq_monitor.sv
// Lock-on checker for the random-sequence counter: tracks position, pulses
// wrap on a locked 0 and error on a locked mismatch, counts errors.
module random_seq_monitor
  import random_seq_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [3:0]       q_in,
  output logic             locked,
  output logic [2:0]       index,
  output logic             wrap,
  output logic             error,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [2:0] LC = 3'(LOCK_COUNT);

  state_t     state;
  logic [3:0] expected;
  logic [2:0] match_cnt;

  logic       member;
  logic [3:0] nxt;
  logic [2:0] q_idx;

  random_seq_lut u_lut (
    .q      (q_in),
    .member (member),
    .nxt    (nxt),
    .index  (q_idx)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= HUNT;
      locked    <= 1'b0;
      index     <= 3'd0;
      wrap      <= 1'b0;
      error     <= 1'b0;
      err_count <= '0;
      expected  <= 4'd0;
      match_cnt <= 3'd0;
    end else begin
      wrap  <= 1'b0;
      error <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            if (member) begin
              expected  <= nxt;
              match_cnt <= 3'd0;
              state     <= CONFIRM;
            end
          end
          CONFIRM: begin
            if (q_in == expected) begin
              match_cnt <= match_cnt + 3'd1;
              expected  <= nxt;
              if (match_cnt + 3'd1 == LC) begin
                state  <= LOCKED;
                locked <= 1'b1;
                index  <= q_idx;
              end
            end else if (member) begin
              expected  <= nxt;
              match_cnt <= 3'd0;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            if (q_in == expected) begin
              index    <= q_idx;
              expected <= nxt;
              wrap     <= (q_in == 4'd0);
            end else begin
              error  <= 1'b1;
              locked <= 1'b0;
              if (err_count != '1) err_count <= err_count + 1'b1;
              // A member value is a plausible new sequence start, so skip HUNT.
              if (member) begin
                expected  <= nxt;
                match_cnt <= 3'd0;
                state     <= CONFIRM;
              end else begin
                state <= HUNT;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_random_seq_monitor.sv
// Bench for random_seq_monitor: directed scenarios plus random traffic against
// a position-based reference model, on an 8-bit and a 2-bit error counter.
module tb_random_seq_monitor;

  logic       clk = 1'b0;
  logic       clear, en;
  logic [3:0] q_in;

  logic       locked_a, wrap_a, error_a;
  logic [2:0] index_a;
  logic [7:0] err_count_a;
  logic       locked_b, wrap_b, error_b;
  logic [2:0] index_b;
  logic [1:0] err_count_b;

  always #5 clk = ~clk;

  random_seq_monitor #(.LOCK_COUNT(3), .ERR_W(8)) dut_a (
    .clk(clk), .clear(clear), .en(en), .q_in(q_in),
    .locked(locked_a), .index(index_a), .wrap(wrap_a), .error(error_a),
    .err_count(err_count_a)
  );

  random_seq_monitor #(.LOCK_COUNT(3), .ERR_W(2)) dut_b (
    .clk(clk), .clear(clear), .en(en), .q_in(q_in),
    .locked(locked_b), .index(index_b), .wrap(wrap_b), .error(error_b),
    .err_count(err_count_b)
  );

  int seq [8] = '{0, 4, 7, 8, 10, 13, 9, 15};

  // Reference model: mode 0=searching, 1=confirming, 2=tracking.
  int m_mode, m_run, m_exp, m_idx, m_errs;
  bit m_locked, m_wrap, m_err;
  bit armed = 0;
  int passed = 0, total = 0;

  function automatic int pos_of(input int v);
    for (int i = 0; i < 8; i++) if (seq[i] == v) return i;
    return -1;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s got %0d want %0d", name, got, want);
  endtask

  task automatic model_step(input bit c, input bit e, input int q);
    int p;
    if (c) begin
      m_mode = 0; m_run = 0; m_exp = 0; m_idx = 0; m_errs = 0;
      m_locked = 0; m_wrap = 0; m_err = 0;
      return;
    end
    m_wrap = 0; m_err = 0;
    if (!e) return;
    p = pos_of(q);
    case (m_mode)
      0: if (p >= 0) begin m_exp = (p + 1) % 8; m_run = 0; m_mode = 1; end
      1: begin
        if (p >= 0 && p == m_exp) begin
          m_run++;
          m_exp = (p + 1) % 8;
          if (m_run == 3) begin m_mode = 2; m_locked = 1; m_idx = p; end
        end else if (p >= 0) begin
          m_exp = (p + 1) % 8; m_run = 0;
        end else m_mode = 0;
      end
      default: begin
        if (p == m_exp) begin
          m_idx = p; m_exp = (p + 1) % 8; m_wrap = (p == 0);
        end else begin
          m_err = 1; m_errs++; m_locked = 0;
          if (p >= 0) begin m_exp = (p + 1) % 8; m_run = 0; m_mode = 1; end
          else m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("locked_a", int'(locked_a), int'(m_locked));
    chk("index_a", int'(index_a), m_idx);
    chk("wrap_a", int'(wrap_a), int'(m_wrap));
    chk("error_a", int'(error_a), int'(m_err));
    chk("err_count_a", int'(err_count_a), sat(m_errs, 8));
    chk("locked_b", int'(locked_b), int'(m_locked));
    chk("index_b", int'(index_b), m_idx);
    chk("error_b", int'(error_b), int'(m_err));
    chk("err_count_b", int'(err_count_b), sat(m_errs, 2));
  endtask

  // Check outputs from the previous edge, then apply the next sample.
  task automatic cyc(input bit c, input bit e, input int q);
    @(negedge clk);
    if (armed) compare_all();
    clear = c; en = e; q_in = 4'(q);
    model_step(c, e, q);
    armed = 1;
  endtask

  task automatic drive_list(input int vals [$]);
    foreach (vals[i]) cyc(0, 1, vals[i]);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  initial begin
    clear = 1; en = 0; q_in = 0;
    cyc(1, 0, 0);
    settle();
    chk("rst_locked", int'(locked_a), 0);
    chk("rst_err_count", int'(err_count_a), 0);

    drive_list('{0, 4, 7, 8});
    settle();
    chk("lock_after_8", int'(locked_a), 1);
    chk("lock_index", int'(index_a), 3);

    drive_list('{10, 13, 9, 15, 0});
    settle();
    chk("wrap_on_0", int'(wrap_a), 1);
    chk("index_at_0", int'(index_a), 0);
    cyc(0, 1, 4);
    settle();
    chk("wrap_drops", int'(wrap_a), 0);

    drive_list('{7, 8, 5});
    settle();
    chk("mismatch_error", int'(error_a), 1);
    chk("mismatch_count", int'(err_count_a), 1);
    chk("mismatch_unlock", int'(locked_a), 0);

    drive_list('{10, 13, 9, 15});
    settle();
    chk("relock", int'(locked_a), 1);
    chk("relock_index", int'(index_a), 7);

    cyc(0, 0, 3); cyc(0, 0, 3); cyc(0, 0, 11); cyc(0, 0, 12); cyc(0, 0, 1);
    cyc(0, 1, 0);
    settle();
    chk("resume_no_error", int'(error_a), 0);
    chk("resume_count", int'(err_count_a), 1);

    cyc(1, 1, 14);
    settle();
    chk("clear_wins_err", int'(error_a), 0);
    chk("clear_wins_cnt", int'(err_count_a), 0);
    chk("clear_wins_lock", int'(locked_a), 0);

    for (int k = 0; k < 5; k++) begin
      drive_list('{0, 4, 7, 8, 5});
      settle();
      chk("sat_err_b", int'(err_count_b), (k < 3) ? k + 1 : 3);
      chk("sat_pulse_b", int'(error_b), 1);
    end

    for (int n = 0; n < 3000; n++) begin
      int r, q;
      r = $urandom_range(99);
      if (m_mode != 0 && r < 75) q = seq[m_exp];
      else if (r < 85) q = seq[$urandom_range(7)];
      else q = $urandom_range(15);
      cyc($urandom_range(99) < 2, $urandom_range(99) < 85, q);
    end
    cyc(0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
